// File: rtl/sha2_pkg.sv
// Shared SHA-2 round-constant definitions: the SHA-512 K table, round counts,
// sequencer state type and a width-aware constant lookup.
package sha2_pkg;

  localparam int unsigned SHA2_ROUNDS_256 = 64;
  localparam int unsigned SHA2_ROUNDS_512 = 80;
  localparam int unsigned SHA2_IDX_W      = 7;

  localparam logic [63:0] SHA2_K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sha2_kseq_state_t;

  // Out-of-range indices return 0; the 32-bit table is the upper half of the 64-bit one.
  function automatic logic [63:0] sha2_k(input logic [SHA2_IDX_W-1:0] idx,
                                         input int unsigned width);
    logic [63:0] k;
    k = '0;
    if (width == 64 && idx < SHA2_IDX_W'(SHA2_ROUNDS_512)) begin
      k = SHA2_K64[idx];
    end else if (width == 32 && idx < SHA2_IDX_W'(SHA2_ROUNDS_256)) begin
      k = {32'h0, SHA2_K64[idx][63:32]};
    end
    return k;
  endfunction

endpackage

// File: rtl/sha2_k_sequencer_if.sv
// Handshake bundle between the control FSM / round datapath (master) and the
// K sequencer (slave).
interface sha2_k_sequencer_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic                             start;
  logic                             k_ready;
  logic                             k_valid;
  logic [WORD_W-1:0]                k_out;
  logic [sha2_pkg::SHA2_IDX_W-1:0]  round_idx;
  logic                             k_last;
  logic                             busy;
  logic                             done;

  modport master (
    output start, k_ready,
    input  k_valid, k_out, round_idx, k_last, busy, done
  );

  modport slave (
    input  start, k_ready,
    output k_valid, k_out, round_idx, k_last, busy, done
  );
endinterface

// File: rtl/sha2_k_rom.sv
// Registered synchronous K ROM: loads K[idx_i] on the edge where en_i is high,
// holds otherwise. Out-of-range indices load 0.
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [SHA2_IDX_W-1:0] idx_i,
  output logic [WORD_W-1:0]     k_o
);
  logic [WORD_W-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (en_i) begin
      k_d = WORD_W'(sha2_k(idx_i, WORD_W));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o = k_q;
endmodule

// File: rtl/sha2_k_sequencer.sv
// Streaming SHA-2 round-constant source (64x32-bit or 80x64-bit) under valid/ready.
// Optional macro SHA2_K_LOOKUP_PORT_EN adds an independent registered lookup port.
module sha2_k_sequencer
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha2_k_sequencer_if.slave        bus
`ifdef SHA2_K_LOOKUP_PORT_EN
  ,
  input  logic [SHA2_IDX_W-1:0]    lk_idx,
  output logic [WORD_W-1:0]        lk_k
`endif
);
  localparam int unsigned ROUNDS = (WORD_W == 64) ? SHA2_ROUNDS_512 : SHA2_ROUNDS_256;
  localparam int unsigned IDX_W  = SHA2_IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUNDS - 1);
  // Any index past the table makes the ROM load 0, which clears k_out.
  localparam logic [IDX_W-1:0] ClearIdx = '1;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_k_sequencer: WORD_W must be 32 or 64");
  end

  sha2_kseq_state_t state_q, state_d;
  logic             k_valid_q, k_valid_d;
  logic             k_last_q, k_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] round_idx_q, round_idx_d;
  logic [IDX_W-1:0] rom_idx;
  logic             rom_en;
  logic             accept;

  assign accept = k_valid_q & bus.k_ready;

  always_comb begin
    state_d     = state_q;
    k_valid_d   = k_valid_q;
    k_last_d    = k_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    round_idx_d = round_idx_q;
    rom_idx     = round_idx_q;
    rom_en      = 1'b0;

    // start wins over everything, including a simultaneous acceptance in RUN.
    if (bus.start) begin
      state_d     = StRun;
      k_valid_d   = 1'b1;
      k_last_d    = (LastIdx == '0);
      busy_d      = 1'b1;
      round_idx_d = '0;
      rom_idx     = '0;
      rom_en      = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (accept) begin
            rom_en = 1'b1;
            if (round_idx_q == LastIdx) begin
              state_d     = StDone;
              k_valid_d   = 1'b0;
              k_last_d    = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              round_idx_d = '0;
              rom_idx     = ClearIdx;
            end else begin
              round_idx_d = round_idx_q + IDX_W'(1);
              rom_idx     = round_idx_d;
              k_last_d    = (round_idx_d == LastIdx);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_valid_q   <= 1'b0;
      k_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      k_valid_q   <= k_valid_d;
      k_last_q    <= k_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      round_idx_q <= round_idx_d;
    end
  end

  sha2_k_rom #(
    .WORD_W (WORD_W)
  ) u_seq_rom (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (rom_en),
    .idx_i  (rom_idx),
    .k_o    (bus.k_out)
  );

`ifdef SHA2_K_LOOKUP_PORT_EN
  sha2_k_rom #(
    .WORD_W (WORD_W)
  ) u_lk_rom (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (1'b1),
    .idx_i  (lk_idx),
    .k_o    (lk_k)
  );
`endif

  assign bus.k_valid   = k_valid_q;
  assign bus.k_last    = k_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.round_idx = round_idx_q;
endmodule

// File: doc/sha2_k_sequencer.md
Name: sha2_k_sequencer

Overview:
- Registered, streaming round-constant source for the SHA-2 compression core.
- Replaces the fixed 32-bit combinational K lookup with one parametrised block that serves SHA-224/256 (64 rounds, 32-bit K) and SHA-384/512 (80 rounds, 64-bit K).
- On start it walks rounds 0..ROUNDS-1, presenting one K per accepted beat under a valid/ready handshake.
- Sits between the top-level control FSM and the round datapath.

Parameters:
- WORD_W, 32, K word width. Legal values are 32 (SHA-224/256) and 64 (SHA-384/512); any other value is an elaboration error.
- ROUNDS, derived localparam (not overridable): 64 when WORD_W=32, 80 when WORD_W=64.
- IDX_W, derived localparam, 7: round index width.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- start  in  1  Begin a new constant sequence from round 0.
- k_ready  in  1  Consumer accepts the current K this cycle.
- k_valid  out  1  k_out and round_idx are valid.
- k_out  out  WORD_W  Round constant K[round_idx].
- round_idx  out  IDX_W  Round number of the presented constant.
- k_last  out  1  High with k_valid when round_idx == ROUNDS-1.
- busy  out  1  High in RUN.
- done  out  1  One-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, k_valid=0, k_out=0, round_idx=0, k_last=0, busy=0, done=0.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN, round_idx=0, k_out=K[0], k_valid=1, all registered (latency 1 cycle from start).
  - Otherwise hold IDLE with outputs at reset values.
- RUN, beat accepted when k_valid && k_ready:
  - If round_idx < ROUNDS-1: round_idx+1 and k_out=K[round_idx+1] on the next edge. Back-to-back beats sustain 1 K/cycle.
  - If round_idx == ROUNDS-1: k_valid=0, k_last=0, k_out=0, round_idx=0, busy=0 -> DONE.
- RUN with k_ready=0: k_out, round_idx and k_last hold stable; k_valid stays 1. Never drop valid without acceptance.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start=1 while in DONE starts a new RUN on the next edge with K[0]; done still pulses in this cycle.
- start=1 in RUN is a restart and has priority over a simultaneous acceptance: next cycle round_idx=0, k_out=K[0], k_valid=1, no done pulse.
- K values:
  - WORD_W=64: full 64-bit SHA-512 constants.
  - WORD_W=32: upper 32 bits of the same table (identical to the SHA-256 constants), rounds 0..63 only.
- round_idx never exceeds ROUNDS-1; the counter does not wrap silently.
- Asserting rst_n low mid-RUN clears all outputs immediately; no done pulse follows.

Optional Feature:
- Macro: SHA2_K_LOOKUP_PORT_EN.
- Defined:
  - Adds ports lk_idx (in, IDX_W) and lk_k (out, WORD_W).
  - lk_k = K[lk_idx], registered one cycle after lk_idx is sampled. Reset value 0.
  - lk_idx >= ROUNDS yields 0.
  - The port is independent of the FSM and usable concurrently with a RUN.
- Undefined: ports absent, no extra logic; the sequencing behaviour is identical either way.

Decomposition:
- Package sha2_pkg:
  - SHA2_K64: the 80-entry table of 64-bit constants.
  - SHA2_ROUNDS_256=64 and SHA2_ROUNDS_512=80.
  - State enum typedef sha2_kseq_state_t (IDLE/RUN/DONE).
  - Function sha2_k(idx, width) returning the width-truncated constant.
- One sub-module: sha2_k_rom, a registered synchronous ROM taking (idx, en) and returning K a cycle later. It is instantiated once for the sequencer and once more for the lookup port when enabled.

Test Plan:
- Reset: hold rst_n=0 with start toggling -> k_valid=0, k_out=0, busy=0, done=0 throughout.
- WORD_W=32, k_ready=1, one-cycle start -> next cycle k_out=32'h428a2f98 with round_idx=0; 64 consecutive beats; round 63 gives 32'hc67178f2 with k_last=1; done pulses exactly once, one cycle after the final beat.
- Backpressure, WORD_W=32: drop k_ready at round 5 for 4 cycles -> k_out stays 32'h59f111f1 and round_idx stays 5; resumes with round 6 = 32'h923f82a4.
- WORD_W=64, k_ready=1 -> round 0 = 64'h428a2f98d728ae22, round 63 = 64'hc67178f2e372532b, round 64 = 64'hca273eceea26619c, round 79 = 64'h6c44198c4a475817 with k_last=1; exactly 80 beats.
- Restart and reset: start pulsed at round 20 -> next cycle round_idx=0, k_out=K[0], no done pulse. Then rst_n low at round 10 -> all outputs 0 immediately, no done pulse after release.
- SHA2_K_LOOKUP_PORT_EN, WORD_W=32: lk_idx=9 -> lk_k=32'h12835b01 one cycle later, during an active RUN. lk_idx=70 -> lk_k=0.
